multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Parametrised multi-cycle RISC-V datapath that succeeds the single-cycle datapath. It sequences each instruction through a FETCH/DECODE/EXECUTE/MEM/WB state machine. Instruction and data memories sit outside the block behind req/ack handshakes, so memories with wait states are supported. An external combinational controller decodes `instruction` and drives the control inputs. The block contains the register file, the immediate generator, the ALU and the PC.

## Interface
- DATA_W, 64, datapath/register width
- INS_W, 32, instruction width
- PC_W, 9, PC / instruction-address width
- DM_ADDRESS, 9, data-memory address width
- RF_ADDRESS, 5, register-index width (2^RF_ADDRESS registers)
- ALU_CC_W, 4, ALU control-code width

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead  in  1 each  control from external controller
- ALU_CC  in  ALU_CC_W  ALU operation select
- Branch  in  1  branch-if-equal select (only when MCDP_BRANCH_EN is defined)
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_rdata  in  INS_W  fetched instruction
- imem_ack  in  1  fetch complete; may be asserted in the same cycle as req
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DM_ADDRESS  = ALUOut[DM_ADDRESS-1:0]
- dmem_wdata  out  DATA_W  = B register (rs2)
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- dmem_ack  in  1  data access complete
- instruction  out  INS_W  instruction register (IR)
- ALUresult  out  DATA_W  ALUOut register
- pc  out  PC_W  current PC
- retire  out  1  one-cycle pulse per completed instruction

## Operation
- **FETCH:** imem_req=1 and imem_addr=pc, held stable until imem_ack. On ack, IR<=imem_rdata and go to DECODE.
- **DECODE:** A<=RF[rs1] (IR[19:15]), B<=RF[rs2] (IR[24:20]), IMM<=immgen(IR). Go to EXECUTE.
- **EXECUTE:** ALUOut<=ALU(A, ALUsrc ? IMM : B). If MemRead|MemWrite go to MEM, else go to WB.
- **MEM:** dmem_req=1, dmem_we=MemWrite, held until dmem_ack.
  - A load latches MDR<=dmem_rdata on ack.
  - MemWrite has priority if both MemRead and MemWrite are high: the access is a store and MDR is not updated.
  - Go to WB.
- **WB:**
  - If RegWrite and rd (IR[11:7]) != 0: RF[rd]<=MemtoReg ? MDR : ALUOut.
  - pc<=pc+4, modulo 2^PC_W (wraps 0x1FC->0x000 at PC_W=9).
  - retire=1. Go to FETCH.
- Register x0 reads 0 and ignores writes.
- Immediates are sign-extended to DATA_W:
  - I-type for opcodes 0000011, 0010011, 1100111
  - S-type for 0100011
  - B-type for 1100011
  - U-type (imm<<12) for 0110111
  - 0 for any other opcode
- ALU_CC encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed, result 0/1), 1100 NOR
  - Any other code produces 0
  - ADD/SUB wrap modulo 2^DATA_W
  - zero flag = (ALU result == 0)
- Control inputs are sampled in whichever state consumes them. The controller must hold them stable from DECODE through WB, which it does naturally because IR is stable over that span.

## Timing
- Reset asserted (asynchronous):
  - state=FETCH; pc, IR, A, B, IMM, ALUOut, MDR and all RF entries = 0
  - imem_req=0, dmem_req=0, dmem_we=0, retire=0
- First cycle after reset release: imem_req=1, imem_addr=0.
- Reset asserted mid-instruction aborts it immediately: requests drop asynchronously and no RF write or retire occurs.
- Latency with zero-wait memories (ack in the same cycle as req):
  - ALU ops: 4 cycles, retire every 4th cycle
  - Loads/stores: 5 cycles
- Each memory wait cycle adds one cycle. No timeout.
- Requests stay high until ack. Exactly one request is issued per access. ack while req=0 is ignored.

## Configuration
- **MCDP_BRANCH_EN defined:** Branch port exists. In EXECUTE with Branch=1, a branch-target register captures pc+IMM[PC_W-1:0] and the zero flag of A-B is latched. ALU_CC is ignored for the branch compare, which always uses SUB. In WB, pc<=target if zero, else pc+4. No RF write occurs when Branch=1.
- **MCDP_BRANCH_EN undefined:** no Branch port and pc always advances by 4.

## Test plan
- Reset, then release with imem_ack tied high → imem_addr 0,4,8 on cycles 1,5,9; retire pulses on cycles 4,8,12 for ALU instructions.
- addi x1,x0,5 then add x2,x1,x1 (ALUsrc=1/0, ALU_CC=0010) → ALUresult 5 then 10; RF[2]=10.
- sw x2,8(x0) with dmem_ack delayed 3 cycles → dmem_req held for 4 cycles with addr 8, wdata 10, we=1; instruction takes 8 cycles.
- lw x3,8(x0) (MemtoReg=1), memory returns 10 → RF[3]=10; then addi x0,x0,7 → x0 still reads 0.
- Reset asserted during MEM with dmem_req high → dmem_req drops in the same cycle, pc=0, no retire.
- MCDP_BRANCH_EN: beq x1,x1,+16 at pc=0x20 → next imem_addr 0x30; beq x1,x0 → 0x24; pc=0x1FC without branch → wraps to 0x000.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multi-cycle RISC-V datapath: FETCH/DECODE/EXECUTE/MEM/WB sequencing with req/ack memory ports.
// Define MCDP_BRANCH_EN to add the Branch input and branch-if-equal PC update.
module multicycle_datapath #(
  parameter int DATA_W     = 64,
  parameter int INS_W      = 32,
  parameter int PC_W       = 9,
  parameter int DM_ADDRESS = 9,
  parameter int RF_ADDRESS = 5,
  parameter int ALU_CC_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic                  ALUsrc,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [ALU_CC_W-1:0]   ALU_CC,
`ifdef MCDP_BRANCH_EN
  input  logic                  Branch,
`endif
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [INS_W-1:0]      imem_rdata,
  input  logic                  imem_ack,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DM_ADDRESS-1:0] dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic [INS_W-1:0]      instruction,
  output logic [DATA_W-1:0]     ALUresult,
  output logic [PC_W-1:0]       pc,
  output logic                  retire
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB} state_e;

  localparam logic [ALU_CC_W-1:0] CC_AND = ALU_CC_W'(4'b0000);
  localparam logic [ALU_CC_W-1:0] CC_OR  = ALU_CC_W'(4'b0001);
  localparam logic [ALU_CC_W-1:0] CC_ADD = ALU_CC_W'(4'b0010);
  localparam logic [ALU_CC_W-1:0] CC_XOR = ALU_CC_W'(4'b0011);
  localparam logic [ALU_CC_W-1:0] CC_SUB = ALU_CC_W'(4'b0110);
  localparam logic [ALU_CC_W-1:0] CC_SLT = ALU_CC_W'(4'b0111);
  localparam logic [ALU_CC_W-1:0] CC_NOR = ALU_CC_W'(4'b1100);

  state_e state_q, state_d;

  logic [PC_W-1:0]   pc_q;
  logic [INS_W-1:0]  ir_q;
  logic [DATA_W-1:0] a_q, b_q, imm_q, aluout_q, mdr_q;
  logic [DATA_W-1:0] rf_q [2**RF_ADDRESS];

  logic [DATA_W-1:0]     imm_d, alu_y, wb_data;
  logic [RF_ADDRESS-1:0] rs1, rs2, rd;
  logic [PC_W-1:0]       pc_inc, pc_next;
  logic                  fetch_c, mem_c, wb_c, br, wb_we;

  function automatic logic [DATA_W-1:0] alu_fn(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y,
                                               input logic [ALU_CC_W-1:0] cc);
    case (cc)
      CC_AND:  return x & y;
      CC_OR:   return x | y;
      CC_ADD:  return x + y;
      CC_XOR:  return x ^ y;
      CC_SUB:  return x - y;
      CC_SLT:  return DATA_W'($signed(x) < $signed(y));
      CC_NOR:  return ~(x | y);
      default: return '0;
    endcase
  endfunction

  assign rs1 = ir_q[15 +: RF_ADDRESS];
  assign rs2 = ir_q[20 +: RF_ADDRESS];
  assign rd  = ir_q[7 +: RF_ADDRESS];

  always_comb begin
    imm_d = '0;
    case (ir_q[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        imm_d = {{(DATA_W-12){ir_q[31]}}, ir_q[31:20]};
      7'b0100011:
        imm_d = {{(DATA_W-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      7'b1100011:
        imm_d = {{(DATA_W-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      7'b0110111:
        imm_d = {{(DATA_W-32){ir_q[31]}}, ir_q[31:12], 12'b0};
      default: imm_d = '0;
    endcase
  end

  assign alu_y  = alu_fn(a_q, ALUsrc ? imm_q : b_q, ALU_CC);
  assign pc_inc = pc_q + PC_W'(4);

`ifdef MCDP_BRANCH_EN
  logic [PC_W-1:0] tgt_q;
  logic            bz_q;

  // Branch compare always subtracts, independent of ALU_CC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_q <= '0;
      bz_q  <= 1'b0;
    end else if (state_q == S_EXECUTE && Branch) begin
      tgt_q <= pc_q + imm_q[PC_W-1:0];
      bz_q  <= (alu_fn(a_q, b_q, CC_SUB) == '0);
    end
  end

  assign br      = Branch;
  assign pc_next = (Branch && bz_q) ? tgt_q : pc_inc;
`else
  assign br      = 1'b0;
  assign pc_next = pc_inc;
`endif

  assign wb_we   = RegWrite && !br && (rd != '0);
  assign wb_data = MemtoReg ? mdr_q : aluout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fetch_c = 1'b0;
    mem_c   = 1'b0;
    wb_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_c = 1'b1;
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = (MemRead || MemWrite) ? S_MEM : S_WB;
      S_MEM: begin
        mem_c = 1'b1;
        if (dmem_ack) state_d = S_WB;
      end
      S_WB: begin
        wb_c    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH:   if (imem_ack) ir_q <= imem_rdata;
        S_DECODE: begin
          a_q   <= rf_q[rs1];
          b_q   <= rf_q[rs2];
          imm_q <= imm_d;
        end
        S_EXECUTE: aluout_q <= alu_y;
        // A store wins when both MemRead and MemWrite are set, so MDR keeps its value.
        S_MEM:     if (dmem_ack && !MemWrite) mdr_q <= dmem_rdata;
        S_WB:      pc_q <= pc_next;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2**RF_ADDRESS; i++) rf_q[i] <= '0;
    end else if (state_q == S_WB && wb_we) begin
      rf_q[rd] <= wb_data;
    end
  end

  // Requests are gated by reset so an abort drops them without waiting for a clock.
  assign imem_req    = reset & fetch_c;
  assign dmem_req    = reset & mem_c;
  assign dmem_we     = reset & mem_c & MemWrite;
  assign retire      = reset & wb_c;
  assign imem_addr   = pc_q;
  assign dmem_addr   = aluout_q[DM_ADDRESS-1:0];
  assign dmem_wdata  = b_q;
  assign instruction = ir_q;
  assign ALUresult   = aluout_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath; branch tests run when MCDP_BRANCH_EN is defined.
module tb_multicycle_datapath;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, reset;
  logic        RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead;
  logic [3:0]  ALU_CC;
  logic        imem_req, imem_ack;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [8:0]  dmem_addr;
  logic [63:0] dmem_wdata, dmem_rdata;
  logic [31:0] instruction;
  logic [63:0] ALUresult;
  logic [8:0]  pc;
  logic        retire;
`ifdef MCDP_BRANCH_EN
  logic        br_drv;
`endif

  int checks = 0;
  int errors = 0;
  int cyc, reqc;
  logic [63:0] res;

  multicycle_datapath dut (
    .clk(clk), .reset(reset),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUsrc(ALUsrc),
    .MemWrite(MemWrite), .MemRead(MemRead), .ALU_CC(ALU_CC),
`ifdef MCDP_BRANCH_EN
    .Branch(br_drv),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .instruction(instruction), .ALUresult(ALUresult), .pc(pc), .retire(retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm, input logic [6:0] op);
    return {imm, rs1, 3'b000, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction
`ifdef MCDP_BRANCH_EN
  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entry/exit point: #1 after a negedge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input logic rw, input logic m2r, input logic asrc,
                           input logic mw, input logic mr, input logic [3:0] cc, input int dly,
                           input logic [63:0] rdata, input logic [8:0] xaddr, input logic [63:0] xwdata,
                           input bit chk_wd, output int ncyc, output int nreq, output logic [63:0] r);
    bit done;
    done = 1'b0;
    imem_rdata = ins; RegWrite = rw; MemtoReg = m2r; ALUsrc = asrc;
    MemWrite = mw; MemRead = mr; ALU_CC = cc; dmem_rdata = rdata;
    ncyc = 0; nreq = 0; r = '0;
    for (int k = 0; k < 64 && !done; k++) begin
      ncyc++;
      if (dmem_req) begin
        nreq++;
        chk("dmem_addr", dmem_addr, xaddr);
        chk("dmem_we", dmem_we, mw);
        if (chk_wd) chk("dmem_wdata", dmem_wdata, xwdata);
        dmem_ack = (nreq > dly);
      end else begin
        dmem_ack = 1'b0;
      end
      if (retire) begin
        r = ALUresult;
        done = 1'b1;
      end
      @(negedge clk); #1;
    end
    dmem_ack = 1'b0;
    if (!done) chk("retire_timeout", done, 1);
  endtask

  task automatic alu_instr(input string tag, input logic [31:0] ins, input logic rw, input logic asrc,
                           input logic [3:0] cc, input logic [63:0] xres);
    int c, q;
    logic [63:0] r;
    run_instr(ins, rw, 1'b0, asrc, 1'b0, 1'b0, cc, 0, '0, '0, '0, 1'b0, c, q, r);
    chk(tag, r, xres);
    chk({tag, "_cycles"}, c, 4);
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = NOP; dmem_ack = 1'b0; dmem_rdata = '0;
    RegWrite = 1'b0; MemtoReg = 1'b0; ALUsrc = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; ALU_CC = '0;
`ifdef MCDP_BRANCH_EN
    br_drv = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_retire", retire, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", instruction, 0);
    chk("rst_aluout", ALUresult, 0);
    chk("rst_wdata", dmem_wdata, 0);

    // Three back-to-back addi x1,x0,5 with zero-wait fetch.
    imem_rdata = enc_i(5'd1, 5'd0, 12'd5, OP_IMM);
    RegWrite = 1'b1; ALUsrc = 1'b1; ALU_CC = ADD;
    @(negedge clk); reset = 1'b1; #1;
    for (int c = 1; c <= 12; c++) begin
      chk("cyc_imem_req", imem_req, (c % 4) == 1);
      if ((c % 4) == 1) chk("cyc_imem_addr", imem_addr, 64'(4 * (c / 4)));
      chk("cyc_retire", retire, (c % 4) == 0);
      if (c == 12) chk("addi_x1", ALUresult, 5);
      @(negedge clk); #1;
    end

    alu_instr("add_x2", enc_r(5'd2, 5'd1, 5'd1), 1'b1, 1'b0, ADD, 64'd10);

    run_instr(enc_s(5'd0, 5'd2, 12'd8), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ADD, 3, '0, 9'd8, 64'd10, 1'b1,
              cyc, reqc, res);
    chk("sw_cycles", cyc, 8);
    chk("sw_req_cycles", reqc, 4);
    chk("sw_aluout", res, 8);

    run_instr(enc_i(5'd3, 5'd0, 12'd8, OP_LOAD), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ADD, 0, 64'd10, 9'd8, '0, 1'b0,
              cyc, reqc, res);
    chk("lw_cycles", cyc, 5);
    chk("lw_req_cycles", reqc, 1);
    alu_instr("read_x3", enc_r(5'd4, 5'd3, 5'd0), 1'b1, 1'b0, ADD, 64'd10);

    alu_instr("addi_x0", enc_i(5'd0, 5'd0, 12'd7, OP_IMM), 1'b1, 1'b1, ADD, 64'd7);
    alu_instr("read_x0", enc_r(5'd5, 5'd0, 5'd0), 1'b1, 1'b0, ADD, 64'd0);

    // Both MemRead and MemWrite: store wins, MDR keeps the earlier load value.
    run_instr(enc_s(5'd0, 5'd2, 12'd16), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ADD, 1, 64'h55, 9'd16, 64'd10, 1'b1,
              cyc, reqc, res);
    chk("rw_cycles", cyc, 6);
    alu_instr("mdr_kept", enc_r(5'd13, 5'd16, 5'd0), 1'b1, 1'b0, ADD, 64'd10);

    alu_instr("and", enc_r(5'd12, 5'd1, 5'd2), 1'b1, 1'b0, 4'b0000, 64'd0);
    alu_instr("or",  enc_r(5'd12, 5'd1, 5'd2), 1'b1, 1'b0, 4'b0001, 64'd15);
    alu_instr("xor", enc_r(5'd12, 5'd1, 5'd2), 1'b1, 1'b0, 4'b0011, 64'd15);
    alu_instr("sub", enc_r(5'd12, 5'd1, 5'd2), 1'b1, 1'b0, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFB);
    alu_instr("slt_lt", enc_r(5'd12, 5'd1, 5'd2), 1'b1, 1'b0, 4'b0111, 64'd1);
    alu_instr("slt_ge", enc_r(5'd12, 5'd2, 5'd1), 1'b1, 1'b0, 4'b0111, 64'd0);
    alu_instr("nor", enc_r(5'd12, 5'd1, 5'd2), 1'b1, 1'b0, 4'b1100, 64'hFFFF_FFFF_FFFF_FFF0);
    alu_instr("bad_cc", enc_r(5'd12, 5'd1, 5'd2), 1'b1, 1'b0, 4'b1111, 64'd0);
    alu_instr("addi_neg", enc_i(5'd6, 5'd0, 12'hFFF, OP_IMM), 1'b1, 1'b1, ADD, 64'hFFFF_FFFF_FFFF_FFFF);
    alu_instr("slt_signed", enc_r(5'd12, 5'd6, 5'd1), 1'b1, 1'b0, 4'b0111, 64'd1);
    alu_instr("lui", enc_u(5'd7, 20'h80000), 1'b1, 1'b1, ADD, 64'hFFFF_FFFF_8000_0000);
    alu_instr("add_wrap", enc_i(5'd8, 5'd6, 12'd1, OP_IMM), 1'b1, 1'b1, ADD, 64'd0);

    // Abort a load that is stalled in MEM.
    imem_rdata = enc_i(5'd3, 5'd0, 12'd8, OP_LOAD);
    RegWrite = 1'b1; MemtoReg = 1'b1; ALUsrc = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ALU_CC = ADD;
    dmem_ack = 1'b0;
    for (int k = 0; k < 10 && !dmem_req; k++) begin
      @(negedge clk); #1;
    end
    chk("abort_mem_reached", dmem_req, 1);
    reset = 1'b0; #1;
    chk("abort_dmem_req", dmem_req, 0);
    chk("abort_retire", retire, 0);
    chk("abort_pc", pc, 0);
    chk("abort_ir", instruction, 0);
    @(negedge clk); #1;
    chk("abort_no_retire", retire, 0);
    chk("abort_imem_req", imem_req, 0);
    reset = 1'b1; #1;
    chk("rel_imem_req", imem_req, 1);
    chk("rel_imem_addr", imem_addr, 0);
    alu_instr("rf_cleared", enc_r(5'd10, 5'd2, 5'd1), 1'b1, 1'b0, ADD, 64'd0);

`ifdef MCDP_BRANCH_EN
    alu_instr("addi_x1_b", enc_i(5'd1, 5'd0, 12'd5, OP_IMM), 1'b1, 1'b1, ADD, 64'd5);
    for (int i = 0; i < 20 && pc != 9'h020; i++) alu_instr("nop_pre_br", NOP, 1'b0, 1'b1, ADD, 64'd0);
    chk("pc_at_20", pc, 9'h020);
    br_drv = 1'b1;
    run_instr(enc_b(5'd1, 5'd1, 13'd16), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0, '0, '0, '0, 1'b0,
              cyc, reqc, res);
    br_drv = 1'b0;
    chk("beq_taken_pc", imem_addr, 9'h030);
    chk("beq_cycles", cyc, 4);
    br_drv = 1'b1;
    run_instr(enc_b(5'd1, 5'd0, 13'd16), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0, '0, '0, '0, 1'b0,
              cyc, reqc, res);
    br_drv = 1'b0;
    chk("beq_not_taken_pc", imem_addr, 9'h034);
    alu_instr("branch_no_rf_write", enc_r(5'd9, 5'd16, 5'd0), 1'b1, 1'b0, ADD, 64'd0);
`endif

    for (int i = 0; i < 200 && pc != 9'h1FC; i++) alu_instr("nop_walk", NOP, 1'b0, 1'b1, ADD, 64'd0);
    chk("pc_at_1fc", pc, 9'h1FC);
    alu_instr("nop_wrap", NOP, 1'b0, 1'b1, ADD, 64'd0);
    chk("pc_wrapped", pc, 0);
    chk("imem_addr_wrapped", imem_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
